mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory stage directly downstream of the execute ALU: takes ALU_out as the effective address.
//  Issues loads/stores on the data bus with a request/response handshake, and aligns store data/strobes.
//  Sign/zero-extends load data; non-memory ops pass through to writeback.
//  One transaction in flight; registered output with valid/ready toward writeback.
// PARAMETERS
//  REG_IDX_W   5   destination register index width
//  MEMOP_W     4   width of in_memop encoding
// PORTS
//  clk          in   1        clock, all state on rising edge
//  resetn       in   1        asynchronous, active-low reset
//  in_valid     in   1        execute has an instruction
//  in_ready     out  1        stage accepts in_* this cycle
//  in_addr      in   64       ALU_out: address for mem ops, result otherwise
//  in_wdata     in   64       store data (rs2 value)
//  in_memop     in   MEMOP_W  0 NONE,1 LB,2 LH,3 LW,4 LD,5 LBU,6 LHU,7 LWU,8 SB,9 SH,10 SW,11 SD
//  in_rd        in   REG_IDX_W destination register
//  in_wen       in   1        instruction writes rd
//  dreq_valid   out  1        bus request valid
//  dreq_addr    out  64       bus address
//  dreq_size    out  3        0=1B 1=2B 2=4B 3=8B
//  dreq_strobe  out  8        byte enables, 0 for loads
//  dreq_data    out  64       lane-aligned store data
//  dresp_ok     in   1        bus completes the current request (data valid for loads)
//  dresp_data   in   64       raw 64-bit aligned word for loads
//  out_valid    out  1        result available for writeback
//  out_ready    in   1        writeback consumes result
//  out_result   out  64       load value or passed-through in_addr
//  out_rd       out  REG_IDX_W destination register
//  out_wen      out  1        write enable (0 for stores/NONE-with-!in_wen/misaligned)
//  out_misalign out  1        access was misaligned (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; dreq_valid, out_valid, out_wen, out_misalign = 0; all data outputs = 0.
//  FSM states:
//   IDLE: in_ready=1. On in_valid:
//    - NONE op: load output regs, go to HOLD.
//    - mem op: latch request fields, go to BUSY.
//   BUSY: dreq_valid=1, request fields stable. in_ready=0. On dresp_ok: capture load result, go to HOLD.
//   HOLD: out_valid=1.
//    - On out_ready && in_valid: accept next op, as from IDLE (back-to-back, no bubble).
//    - On out_ready && !in_valid: go to IDLE.
//  in_ready = IDLE | (HOLD & out_ready). Outputs are stable while out_valid=1 and out_ready=0.
//  Latency:
//   - NONE op accepted at T gives out_valid at T+1.
//   - mem op accepted at T gives dreq_valid from T+1; dresp_ok at D gives out_valid at D+1.
//   - Minimum mem latency is 2 cycles (dresp_ok in first BUSY cycle).
//  Store alignment:
//   - off = addr[2:0].
//   - dreq_data = in_wdata << (8*off).
//   - dreq_strobe = (SB 8'h01 | SH 8'h03 | SW 8'h0F | SD 8'hFF) << off.
//  Load alignment:
//   - raw = dresp_data >> (8*off), truncated to the access size.
//   - LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend; LD takes raw as-is.
//  dreq_addr = in_addr unmodified when aligned.
//  Stores: out_wen=0, out_result=0.
//  Misaligned: addr not a multiple of the access size.
//  dresp_ok outside BUSY is ignored.
//  Async reset mid-BUSY: dreq_valid drops immediately; a late dresp_ok is ignored.
//  Undefined memop codes (12-15) are treated as NONE.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   - Misaligned op issues no bus request.
//   - Goes IDLE->HOLD in 1 cycle with out_misalign=1, out_wen=0, out_result=in_addr.
//  Undefined:
//   - Address low bits are cleared to the access size (aligned down) and the access proceeds normally.
//   - out_misalign is tied to 0.
// TESTING
//  1 NONE op, in_addr=64'h1234, in_wen=1, rd=5, out_ready=1
//    -> next cycle out_valid=1, out_result=64'h1234, out_rd=5, out_wen=1.
//  2 LB addr=64'h1003, dresp_data=64'h0000_0000_8000_0000 after 3 cycles
//    -> out_result=64'hFFFF_FFFF_FFFF_FF80; LBU same -> 64'h80.
//  3 SH addr=64'h2006, wdata=64'hBEEF
//    -> dreq_strobe=8'hC0, dreq_data=64'hBEEF_0000_0000_0000, dreq_size=1, out_wen=0.
//  4 LW addr=64'h3002
//    -> TRAP_EN: no dreq_valid, out_misalign=1 at T+1.
//    -> else: dreq_addr=64'h3000, out_misalign=0.
//  5 out_ready=0 for 4 cycles after a LD result
//    -> out_* stable, in_ready=0; two back-to-back NONE ops with out_ready=1 complete on consecutive cycles.
//  6 resetn low during BUSY, dresp_ok pulsed after release
//    -> dreq_valid=0 at once, state IDLE, no out_valid.

Source files
------------

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : Memory stage following the execute ALU. Uses the ALU result as
//            the effective address, issues one load/store at a time on a
//            request/response data bus, lane-aligns store data and strobes,
//            sign/zero-extends load data, and passes non-memory ops through
//            to writeback behind a registered valid/ready output.
// Build    : MEM_MISALIGN_TRAP_EN - when defined, misaligned accesses are not
//            issued; they complete in one cycle with out_misalign=1. When
//            undefined, the address is aligned down to the access size.
// Ports    : clk, resetn (async, active-low)
//            in_valid/in_ready, in_addr, in_wdata, in_memop, in_rd, in_wen
//            dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data
//            dresp_ok, dresp_data
//            out_valid/out_ready, out_result, out_rd, out_wen, out_misalign
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
  parameter int REG_IDX_W = 5,
  parameter int MEMOP_W   = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_addr,
  input  logic [63:0]          in_wdata,
  input  logic [MEMOP_W-1:0]   in_memop,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_wen,
  output logic                 dreq_valid,
  output logic [63:0]          dreq_addr,
  output logic [2:0]           dreq_size,
  output logic [7:0]           dreq_strobe,
  output logic [63:0]          dreq_data,
  input  logic                 dresp_ok,
  input  logic [63:0]          dresp_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_result,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_wen,
  output logic                 out_misalign
);

  localparam logic [MEMOP_W-1:0] OP_LB  = MEMOP_W'(1);
  localparam logic [MEMOP_W-1:0] OP_LH  = MEMOP_W'(2);
  localparam logic [MEMOP_W-1:0] OP_LW  = MEMOP_W'(3);
  localparam logic [MEMOP_W-1:0] OP_LD  = MEMOP_W'(4);
  localparam logic [MEMOP_W-1:0] OP_LBU = MEMOP_W'(5);
  localparam logic [MEMOP_W-1:0] OP_LHU = MEMOP_W'(6);
  localparam logic [MEMOP_W-1:0] OP_LWU = MEMOP_W'(7);
  localparam logic [MEMOP_W-1:0] OP_SB  = MEMOP_W'(8);
  localparam logic [MEMOP_W-1:0] OP_SH  = MEMOP_W'(9);
  localparam logic [MEMOP_W-1:0] OP_SW  = MEMOP_W'(10);
  localparam logic [MEMOP_W-1:0] OP_SD  = MEMOP_W'(11);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   dreq_valid_q;
  logic [63:0]            dreq_addr_q;
  logic [2:0]             dreq_size_q;
  logic [7:0]             dreq_strobe_q;
  logic [63:0]            dreq_data_q;
  logic [MEMOP_W-1:0]     memop_q;
  logic                   is_load_q;
  logic                   wen_q;
  logic                   out_valid_q;
  logic [63:0]            out_result_q;
  logic [REG_IDX_W-1:0]   out_rd_q;
  logic                   out_wen_q;

  // Decode of the incoming op
  logic        dec_load;
  logic        dec_store;
  logic [1:0]  dec_size;
  logic [2:0]  dec_mask;
  logic [63:0] dec_addr;
  logic [2:0]  dec_off;
  logic [7:0]  dec_strobe;
  logic [63:0] dec_data;
  logic        accept;

  // Load data extraction from the raw bus word
  logic [63:0] ld_raw;
  logic [63:0] ld_value;

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_size  = 2'd0;
    case (in_memop)
      OP_LB, OP_LBU: begin dec_load  = 1'b1; dec_size = 2'd0; end
      OP_LH, OP_LHU: begin dec_load  = 1'b1; dec_size = 2'd1; end
      OP_LW, OP_LWU: begin dec_load  = 1'b1; dec_size = 2'd2; end
      OP_LD:         begin dec_load  = 1'b1; dec_size = 2'd3; end
      OP_SB:         begin dec_store = 1'b1; dec_size = 2'd0; end
      OP_SH:         begin dec_store = 1'b1; dec_size = 2'd1; end
      OP_SW:         begin dec_store = 1'b1; dec_size = 2'd2; end
      OP_SD:         begin dec_store = 1'b1; dec_size = 2'd3; end
      default:       ; // NONE and undefined codes pass through
    endcase

    case (dec_size)
      2'd0:    dec_mask = 3'b000;
      2'd1:    dec_mask = 3'b001;
      2'd2:    dec_mask = 3'b011;
      default: dec_mask = 3'b111;
    endcase

    // Aligning down is a no-op for aligned accesses, so the trap build
    // can share this path for the accesses it actually issues.
    dec_addr = {in_addr[63:3], in_addr[2:0] & ~dec_mask};
    dec_off  = dec_addr[2:0];

    dec_strobe = 8'h00;
    dec_data   = 64'd0;
    if (dec_store) begin
      case (dec_size)
        2'd0:    dec_strobe = 8'h01 << dec_off;
        2'd1:    dec_strobe = 8'h03 << dec_off;
        2'd2:    dec_strobe = 8'h0F << dec_off;
        default: dec_strobe = 8'hFF << dec_off;
      endcase
      dec_data = in_wdata << {dec_off, 3'b000};
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic dec_misalign;
  logic out_misalign_q;
  assign dec_misalign = |(in_addr[2:0] & dec_mask);
  assign out_misalign = out_misalign_q;
`else
  assign out_misalign = 1'b0;
`endif

  always_comb begin
    ld_raw = dresp_data >> {dreq_addr_q[2:0], 3'b000};
    case (memop_q)
      OP_LB:   ld_value = {{56{ld_raw[7]}},  ld_raw[7:0]};
      OP_LH:   ld_value = {{48{ld_raw[15]}}, ld_raw[15:0]};
      OP_LW:   ld_value = {{32{ld_raw[31]}}, ld_raw[31:0]};
      OP_LD:   ld_value = ld_raw;
      OP_LBU:  ld_value = {56'd0, ld_raw[7:0]};
      OP_LHU:  ld_value = {48'd0, ld_raw[15:0]};
      OP_LWU:  ld_value = {32'd0, ld_raw[31:0]};
      default: ld_value = 64'd0; // stores report a zero result
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= 64'd0;
      dreq_size_q   <= 3'd0;
      dreq_strobe_q <= 8'h00;
      dreq_data_q   <= 64'd0;
      memop_q       <= '0;
      is_load_q     <= 1'b0;
      wen_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= 64'd0;
      out_rd_q      <= '0;
      out_wen_q     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      out_misalign_q <= 1'b0;
`endif
    end else if (accept) begin
      // Accept from IDLE, or from HOLD while writeback drains (no bubble)
      out_rd_q <= in_rd;
      if (!(dec_load | dec_store)) begin
        state_q      <= S_HOLD;
        out_valid_q  <= 1'b1;
        out_result_q <= in_addr;
        out_wen_q    <= in_wen;
`ifdef MEM_MISALIGN_TRAP_EN
        out_misalign_q <= 1'b0;
      end else if (dec_misalign) begin
        state_q        <= S_HOLD;
        out_valid_q    <= 1'b1;
        out_result_q   <= in_addr;
        out_wen_q      <= 1'b0;
        out_misalign_q <= 1'b1;
`endif
      end else begin
        state_q       <= S_BUSY;
        out_valid_q   <= 1'b0;
        dreq_valid_q  <= 1'b1;
        dreq_addr_q   <= dec_addr;
        dreq_size_q   <= {1'b0, dec_size};
        dreq_strobe_q <= dec_strobe;
        dreq_data_q   <= dec_data;
        memop_q       <= in_memop;
        is_load_q     <= dec_load;
        wen_q         <= in_wen;
      end
    end else begin
      case (state_q)
        S_BUSY: begin
          if (dresp_ok) begin
            state_q      <= S_HOLD;
            dreq_valid_q <= 1'b0;
            out_valid_q  <= 1'b1;
            out_result_q <= ld_value;
            out_wen_q    <= is_load_q & wen_q;
`ifdef MEM_MISALIGN_TRAP_EN
            out_misalign_q <= 1'b0;
`endif
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        S_IDLE: ;
        default: begin
          state_q      <= S_IDLE;
          dreq_valid_q <= 1'b0;
          out_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = dreq_addr_q;
  assign dreq_size   = dreq_size_q;
  assign dreq_strobe = dreq_strobe_q;
  assign dreq_data   = dreq_data_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_wen     = out_wen_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access: directed cases followed by
//            randomized transactions compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic [3:0]  in_memop;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_ok;
  logic [63:0] dresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        out_misalign;

  int checks   = 0;
  int failures = 0;

`ifdef MEM_MISALIGN_TRAP_EN
  bit trap_en = 1'b1;
`else
  bit trap_en = 1'b0;
`endif

  mem_access #(.REG_IDX_W(5), .MEMOP_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_memop(in_memop), .in_rd(in_rd), .in_wen(in_wen),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wen(out_wen), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: what the stage should do with one instruction.
  task automatic model(
    input  logic [3:0]  op, input logic [63:0] addr, input logic [63:0] wdata,
    input  logic [63:0] resp, input logic wen,
    output bit          bus, output bit is_st,
    output logic [63:0] e_addr, output logic [2:0] e_size,
    output logic [7:0]  e_strb, output logic [63:0] e_data,
    output logic [63:0] e_res, output logic e_wen, output logic e_mis);
    int unsigned n;
    int unsigned off;
    bit ld, sgn, mis;
    logic [63:0] mask, raw;
    ld = 0; is_st = 0; sgn = 0; n = 1;
    case (op)
      4'd1:  begin ld = 1; sgn = 1; n = 1; end
      4'd2:  begin ld = 1; sgn = 1; n = 2; end
      4'd3:  begin ld = 1; sgn = 1; n = 4; end
      4'd4:  begin ld = 1; n = 8; end
      4'd5:  begin ld = 1; n = 1; end
      4'd6:  begin ld = 1; n = 2; end
      4'd7:  begin ld = 1; n = 4; end
      4'd8:  begin is_st = 1; n = 1; end
      4'd9:  begin is_st = 1; n = 2; end
      4'd10: begin is_st = 1; n = 4; end
      4'd11: begin is_st = 1; n = 8; end
      default: ;
    endcase
    mis    = (ld || is_st) && ((addr % n) != 0);
    e_addr = addr - (addr % n);
    off    = int'(e_addr % 8);
    e_size = 3'($clog2(n));
    e_strb = is_st ? 8'(((1 << n) - 1) << off) : 8'h00;
    e_data = is_st ? (wdata << (8 * off)) : 64'd0;
    mask   = (n == 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);
    raw    = (resp >> (8 * off)) & mask;
    if (sgn && raw[8*n-1]) raw = raw | ~mask;
    e_mis  = 1'b0;
    if (!(ld || is_st)) begin
      bus = 0; e_res = addr; e_wen = wen;
    end else if (mis && trap_en) begin
      bus = 0; e_res = addr; e_wen = 1'b0; e_mis = 1'b1;
    end else begin
      bus = 1; e_res = ld ? raw : 64'd0; e_wen = ld ? wen : 1'b0;
    end
  endtask

  // One full transaction from an idle stage: issue, optional bus phase,
  // result with 'hold' cycles of writeback backpressure, then drain.
  task automatic run_txn(input logic [3:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] resp,
                         input logic [4:0] rd, input logic wen,
                         input int delay, input int hold);
    bit bus, is_st;
    logic [63:0] e_addr, e_data, e_res;
    logic [2:0]  e_size;
    logic [7:0]  e_strb;
    logic        e_wen, e_mis;
    model(op, addr, wdata, resp, wen, bus, is_st, e_addr, e_size, e_strb, e_data, e_res, e_wen, e_mis);
    @(negedge clk);
    in_valid = 1; in_memop = op; in_addr = addr; in_wdata = wdata;
    in_rd = rd; in_wen = wen; out_ready = 1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    in_addr  = 64'(~addr);
    in_wdata = 64'(~wdata);
    if (bus) begin
      chk("dreq_valid", 64'(dreq_valid), 64'd1);
      chk("dreq_addr", dreq_addr, e_addr);
      chk("dreq_size", 64'(dreq_size), 64'(e_size));
      chk("dreq_strobe", 64'(dreq_strobe), 64'(e_strb));
      if (is_st) chk("dreq_data", dreq_data, e_data);
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < delay; i++) begin
        @(posedge clk); #1;
        chk("busy_dreq_valid", 64'(dreq_valid), 64'd1);
        chk("busy_dreq_addr", dreq_addr, e_addr);
        chk("busy_out_valid", 64'(out_valid), 64'd0);
      end
      dresp_ok = 1; dresp_data = resp;
      if (hold > 0) out_ready = 0;
      @(posedge clk); #1;
      dresp_ok = 0; dresp_data = {$urandom, $urandom};
    end else begin
      chk("no_dreq", 64'(dreq_valid), 64'd0);
      if (hold > 0) out_ready = 0;
    end
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("out_result", out_result, e_res);
    chk("out_rd", 64'(out_rd), 64'(rd));
    chk("out_wen", 64'(out_wen), 64'(e_wen));
    chk("out_misalign", 64'(out_misalign), 64'(e_mis));
    chk("dreq_dropped", 64'(dreq_valid), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", out_result, e_res);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    resetn = 0; in_valid = 0; in_addr = 0; in_wdata = 0; in_memop = 0;
    in_rd = 0; in_wen = 0; dresp_ok = 0; dresp_data = 0; out_ready = 0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst_out_wen", 64'(out_wen), 64'd0);
    chk("rst_out_misalign", 64'(out_misalign), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_dreq_addr", dreq_addr, 64'd0);
    @(negedge clk); resetn = 1;

    // Directed cases
    run_txn(4'd0,  64'h1234, 64'h0, 64'h0, 5'd5, 1'b1, 0, 0);
    run_txn(4'd0,  64'h55AA, 64'h0, 64'h0, 5'd9, 1'b0, 0, 0);
    run_txn(4'd1,  64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd3, 1'b1, 2, 0);
    run_txn(4'd5,  64'h1003, 64'h0, 64'h0000_0000_8000_0000, 5'd3, 1'b1, 2, 0);
    run_txn(4'd9,  64'h2006, 64'hBEEF, 64'h0, 5'd7, 1'b1, 0, 0);
    run_txn(4'd3,  64'h3002, 64'h0, 64'hDEAD_BEEF_8765_4321, 5'd4, 1'b1, 1, 0);
    run_txn(4'd4,  64'h4008, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd6, 1'b1, 0, 4);
    run_txn(4'd11, 64'h5000, 64'hCAFE_F00D_1234_5678, 64'h0, 5'd8, 1'b1, 0, 0);
    run_txn(4'd13, 64'h7777, 64'h0, 64'h0, 5'd2, 1'b1, 0, 0);

    // Two back-to-back NONE ops complete on consecutive cycles
    @(negedge clk);
    in_valid = 1; in_memop = 0; in_addr = 64'hA1; in_rd = 5'd1; in_wen = 1; out_ready = 1;
    @(posedge clk); #1;
    chk("b2b_first_valid", 64'(out_valid), 64'd1);
    chk("b2b_first_result", out_result, 64'hA1);
    in_addr = 64'hB2; in_rd = 5'd2;
    chk("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0;
    chk("b2b_second_valid", 64'(out_valid), 64'd1);
    chk("b2b_second_result", out_result, 64'hB2);
    chk("b2b_second_rd", 64'(out_rd), 64'd2);
    @(posedge clk); #1;
    chk("b2b_drain", 64'(out_valid), 64'd0);

    // Reset during BUSY, then a late response
    @(negedge clk);
    in_valid = 1; in_memop = 4'd4; in_addr = 64'h8000; in_rd = 5'd10; in_wen = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk("rstbusy_dreq_valid", 64'(dreq_valid), 64'd1);
    #2 resetn = 0;
    #1;
    chk("rstbusy_dreq_drop", 64'(dreq_valid), 64'd0);
    @(posedge clk); #1;
    resetn = 1;
    dresp_ok = 1; dresp_data = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    dresp_ok = 0;
    chk("rstbusy_no_out", 64'(out_valid), 64'd0);
    chk("rstbusy_no_req", 64'(dreq_valid), 64'd0);
    chk("rstbusy_idle", 64'(in_ready), 64'd1);

    // Stray response while idle
    dresp_ok = 1;
    @(posedge clk); #1;
    dresp_ok = 0;
    chk("stray_resp", 64'(out_valid), 64'd0);

    // Randomized transactions
    for (int t = 0; t < 80; t++) begin
      logic [3:0]  op;
      logic [63:0] a, w, r;
      op = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      w  = {$urandom, $urandom};
      r  = {$urandom, $urandom};
      run_txn(op, a, w, r, 5'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
